// File: rtl/seqgen_pkg.sv
// Shared types and constants for the seqgen framed serial generator.
package seqgen_pkg;

    typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;

    localparam logic [4:0] PREAMBLE = 5'b11010;
    localparam int         PRE_LEN  = 5;
    localparam int         CNT_W    = 6;

    // Preamble is sent from bit PRE_LEN-1 down to bit 0.
    function automatic logic pre_bit(input logic [CNT_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < PRE_LEN; i++) begin
            if (idx == CNT_W'(i)) b = PREAMBLE[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/seqgen_bitcnt.sv
// Loadable down-counter with a terminal-count flag; times the preamble, payload and gap phases.
module seqgen_bitcnt
    import seqgen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/seqgen.sv
// Serial frame generator: preamble 11010, payload MSB first, optional even parity, then idle gap.
module seqgen
    import seqgen_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1,
    parameter int GAP_LEN   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dout,
    output logic              dout_en,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg;
    logic              par;
    logic [CNT_W-1:0]  cnt, load_val;
    logic              cnt_load, cnt_dec, tc;
    logic              dout_n, dout_en_n, done_n, capture, shift;

    seqgen_bitcnt u_bitcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .tc       (tc)
    );

    assign in_ready = rst && (state == IDLE);

    // Outputs are computed one cycle ahead so dout reflects the state it is registered into.
    always_comb begin
        state_n   = state;
        dout_n    = 1'b0;
        dout_en_n = 1'b0;
        done_n    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        load_val  = '0;
        capture   = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n   = PRE;
                    cnt_load  = 1'b1;
                    load_val  = PRE_LOAD;
                    capture   = 1'b1;
                    dout_n    = PREAMBLE[PRE_LEN-1];
                    dout_en_n = 1'b1;
                end
            end
            PRE: begin
                dout_en_n = 1'b1;
                if (!tc) begin
                    cnt_dec = 1'b1;
                    dout_n  = pre_bit(cnt - CNT_W'(1));
                end else begin
                    state_n  = DATA;
                    cnt_load = 1'b1;
                    load_val = DATA_LOAD;
                    dout_n   = shreg[DATA_W-1];
                    shift    = 1'b1;
                end
            end
            DATA: begin
                if (!tc) begin
                    cnt_dec   = 1'b1;
                    dout_n    = shreg[DATA_W-1];
                    dout_en_n = 1'b1;
                    shift     = 1'b1;
                end else if (PARITY_EN != 0) begin
                    state_n   = PAR;
                    dout_n    = par;
                    dout_en_n = 1'b1;
                end else begin
                    done_n = 1'b1;
                    if (GAP_LEN > 0) begin
                        state_n  = GAP;
                        cnt_load = 1'b1;
                        load_val = GAP_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            PAR: begin
                done_n = 1'b1;
                if (GAP_LEN > 0) begin
                    state_n  = GAP;
                    cnt_load = 1'b1;
                    load_val = GAP_LOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (tc) state_n = IDLE;
                else    cnt_dec = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Parity is taken from the captured word so later in_data changes cannot leak into the frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout       <= 1'b0;
            dout_en    <= 1'b0;
            frame_done <= 1'b0;
            shreg      <= '0;
            par        <= 1'b0;
        end else begin
            dout       <= dout_n;
            dout_en    <= dout_en_n;
            frame_done <= done_n;
            if (capture) begin
                shreg <= in_data;
                par   <= ^in_data;
            end else if (shift) begin
                shreg <= {shreg[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule
